hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit_pkg.sv | 20 ++
 rtl/hazard_stall_unit_sat_counter.sv | 29 ++
 rtl/hazard_stall_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall unit.
//   state_t     : control FSM encoding (RUN, MEMWAIT)
//   REG_W       : register-index width
//   WDOG_W      : memory watchdog width
//   WDOG_LIMIT  : watchdog value at which a memory access is declared hung
//   SC_W        : stall-cycle counter width
package hazard_stall_unit_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_t;

  localparam int REG_W  = 3;
  localparam int WDOG_W = 8;
  localparam int SC_W   = 16;

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 8'd255;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count up by one, holding at all-ones
//   count    : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard and stall controller.
// Detects load-use hazards, sequences branch flushes and freezes the
// pipeline while data memory is busy, with a watchdog that gives up on a
// hung memory access.
//   clk, rst                         : clock, asynchronous active-high reset
//   Rs_if_id, Rt_if_id (+ _valid)    : IF/ID source registers
//   Rd_id_ex, Rd_valid_id_ex,
//   WriteReg_id_ex, MemRead_id_ex    : ID/EX destination and load flags
//   branch_taken_ex                  : branch resolved taken in EX
//   mem_stall, mem_done              : data memory busy / access complete
//   stall_pc, stall_if_id            : hold PC and IF/ID (load-use)
//   bubble_id_ex                     : insert NOP into ID/EX (load-use)
//   flush_if_id, flush_id_ex         : squash younger instructions
//   stall_all                        : freeze entire pipeline (memory wait)
//   mem_timeout                      : sticky watchdog error
//   stall_cycles                     : saturating count of stalled cycles
//
// state   | meaning
// RUN     | normal flow; load-use and flush handling active
// MEMWAIT | data memory busy; pipeline frozen until done or watchdog expiry
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs_if_id,
  input  logic [REG_W-1:0] Rt_if_id,
  input  logic             Rs_valid_if_id,
  input  logic             Rt_valid_if_id,
  input  logic [REG_W-1:0] Rd_id_ex,
  input  logic             Rd_valid_id_ex,
  input  logic             WriteReg_id_ex,
  input  logic             MemRead_id_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_stall,
  input  logic             mem_done,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_all,
  output logic             mem_timeout,
  output logic [SC_W-1:0]  stall_cycles
);

  state_t              state, state_nxt;
  logic                pending_flush, pending_nxt;
  logic                timeout_nxt;
  logic [WDOG_W-1:0]   wdog;
  logic                wdog_clr, wdog_inc;
  logic                lu, stall_all_i, flush_i, lu_act;

  assign lu = MemRead_id_ex & WriteReg_id_ex & Rd_valid_id_ex &
              ((Rs_valid_if_id & (Rs_if_id == Rd_id_ex)) |
               (Rt_valid_if_id & (Rt_if_id == Rd_id_ex)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      pending_flush <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending_flush <= pending_nxt;
      mem_timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_flush;
    timeout_nxt = mem_timeout;
    stall_all_i = 1'b0;
    wdog_clr    = 1'b0;
    wdog_inc    = 1'b0;
    flush_i     = 1'b0;
    lu_act      = 1'b0;

    case (state)
      ST_RUN: begin
        // Once the watchdog has fired, memory busy requests are ignored.
        if (mem_stall && !mem_done && !mem_timeout) begin
          stall_all_i = 1'b1;
          wdog_clr    = 1'b1;
          state_nxt   = ST_MEMWAIT;
        end
      end
      ST_MEMWAIT: begin
        wdog_inc = 1'b1;
        if (mem_done) begin
          state_nxt = ST_RUN;
        end else begin
          stall_all_i = ~mem_timeout;
          // Counter reaches the limit on this edge: 255th wait cycle.
          if (wdog == (WDOG_LIMIT - 8'd1)) begin
            timeout_nxt = 1'b1;
            state_nxt   = ST_RUN;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    // A branch resolved while frozen is remembered and replayed on the
    // first unfrozen cycle.
    flush_i = ~stall_all_i & (branch_taken_ex | pending_flush);
    lu_act  = ~stall_all_i & ~flush_i & lu;

    if (stall_all_i && branch_taken_ex) begin
      pending_nxt = 1'b1;
    end else if (flush_i) begin
      pending_nxt = 1'b0;
    end
  end

  assign stall_all    = stall_all_i & ~rst;
  assign flush_if_id  = flush_i & ~rst;
  assign flush_id_ex  = flush_i & ~rst;
  assign stall_pc     = lu_act & ~rst;
  assign stall_if_id  = lu_act & ~rst;
  assign bubble_id_ex = lu_act & ~rst;

  sat_counter #(.W(WDOG_W)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wdog_clr),
    .inc   (wdog_inc),
    .count (wdog)
  );

  sat_counter #(.W(SC_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (stall_pc | stall_all),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: each stimulus cycle pushes its
// hand-derived expected outputs; a negedge monitor pops and compares.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  Rs_if_id, Rt_if_id, Rd_id_ex;
  logic        Rs_valid_if_id, Rt_valid_if_id;
  logic        Rd_valid_id_ex, WriteReg_id_ex, MemRead_id_ex;
  logic        branch_taken_ex, mem_stall, mem_done;
  logic        stall_pc, stall_if_id, bubble_id_ex;
  logic        flush_if_id, flush_id_ex, stall_all, mem_timeout;
  logic [15:0] stall_cycles;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_sc = '0;
  logic [22:0] exp_q[$];
  string       name_q[$];

  hazard_stall_unit dut (
    .clk             (clk),
    .rst             (rst),
    .Rs_if_id        (Rs_if_id),
    .Rt_if_id        (Rt_if_id),
    .Rs_valid_if_id  (Rs_valid_if_id),
    .Rt_valid_if_id  (Rt_valid_if_id),
    .Rd_id_ex        (Rd_id_ex),
    .Rd_valid_id_ex  (Rd_valid_id_ex),
    .WriteReg_id_ex  (WriteReg_id_ex),
    .MemRead_id_ex   (MemRead_id_ex),
    .branch_taken_ex (branch_taken_ex),
    .mem_stall       (mem_stall),
    .mem_done        (mem_done),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .stall_all       (stall_all),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [22:0] e;
    logic [22:0] a;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex,
           stall_all, mem_timeout, stall_cycles};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc/if/bub/fif/fex/sa/to=%b sc=%0d, expected %b sc=%0d",
                 n, a[22:16], a[15:0], e[22:16], e[15:0]);
      end
    end
  end

  task automatic idle();
    rst             = 1'b0;
    Rs_if_id        = 3'd0;
    Rt_if_id        = 3'd0;
    Rd_id_ex        = 3'd0;
    Rs_valid_if_id  = 1'b0;
    Rt_valid_if_id  = 1'b0;
    Rd_valid_id_ex  = 1'b0;
    WriteReg_id_ex  = 1'b0;
    MemRead_id_ex   = 1'b0;
    branch_taken_ex = 1'b0;
    mem_stall       = 1'b0;
    mem_done        = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Load in ID/EX writing r<rd>; IF/ID reads rs (valid) and rt (valid).
  task automatic load_use(input logic [2:0] rd, input logic [2:0] rs, input logic rsv,
                          input logic [2:0] rt, input logic rtv);
    Rd_id_ex       = rd;
    Rd_valid_id_ex = 1'b1;
    WriteReg_id_ex = 1'b1;
    MemRead_id_ex  = 1'b1;
    Rs_if_id       = rs;
    Rs_valid_if_id = rsv;
    Rt_if_id       = rt;
    Rt_valid_if_id = rtv;
  endtask

  // Expected outputs for the cycle just driven; stall_cycles shows the
  // count before this cycle's increment.
  task automatic chk(input string nm, input logic e_pc, input logic e_fl,
                     input logic e_sa, input logic e_to);
    logic [15:0] sc;
    if (rst) exp_sc = '0;
    sc = exp_sc;
    if ((e_pc || e_sa) && !rst && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    exp_q.push_back({e_pc, e_pc, e_pc, e_fl, e_fl, e_sa, e_to, sc});
    name_q.push_back(nm);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b1; chk("reset_0", 0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b1; load_use(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    branch_taken_ex = 1'b1; mem_stall = 1'b1;
    chk("reset_gates_outputs", 0, 0, 0, 0);
    nxt(); chk("idle", 0, 0, 0, 0);

    // load-use via Rs, one cycle
    nxt(); load_use(3'd3, 3'd3, 1'b1, 3'd0, 1'b0); chk("lu_rs", 1, 0, 0, 0);
    nxt(); chk("lu_done_sc1", 0, 0, 0, 0);
    // load-use via Rt
    nxt(); load_use(3'd5, 3'd2, 1'b1, 3'd5, 1'b1); chk("lu_rt", 1, 0, 0, 0);
    // matching fields but not real hazards
    nxt(); load_use(3'd4, 3'd4, 1'b0, 3'd4, 1'b0); chk("no_lu_invalid_src", 0, 0, 0, 0);
    nxt(); load_use(3'd4, 3'd4, 1'b1, 3'd0, 1'b0); MemRead_id_ex = 1'b0;
    chk("no_lu_not_load", 0, 0, 0, 0);
    nxt(); load_use(3'd4, 3'd4, 1'b1, 3'd0, 1'b0); Rd_valid_id_ex = 1'b0;
    chk("no_lu_rd_invalid", 0, 0, 0, 0);
    nxt(); load_use(3'd4, 3'd4, 1'b1, 3'd0, 1'b0); WriteReg_id_ex = 1'b0;
    chk("no_lu_no_write", 0, 0, 0, 0);
    nxt(); load_use(3'd6, 3'd1, 1'b1, 3'd2, 1'b1); chk("no_lu_mismatch", 0, 0, 0, 0);
    // flush beats load-use
    nxt(); load_use(3'd3, 3'd3, 1'b1, 3'd0, 1'b0); branch_taken_ex = 1'b1;
    chk("lu_with_branch", 0, 1, 0, 0);
    nxt(); chk("after_branch", 0, 0, 0, 0);

    // 4-cycle memory wait, load-use suppressed while frozen
    nxt(); mem_stall = 1'b1; chk("mw_c1", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; chk("mw_c2", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; load_use(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    chk("mw_c3_lu_masked", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; chk("mw_c4", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; mem_done = 1'b1; chk("mw_done", 0, 0, 0, 0);
    nxt(); chk("mw_after_sc", 0, 0, 0, 0);

    // branch during wait is deferred to the done cycle
    nxt(); mem_stall = 1'b1; chk("pf_c1", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; branch_taken_ex = 1'b1; chk("pf_c2_branch", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; chk("pf_c3", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; chk("pf_c4", 0, 0, 1, 0);
    nxt(); mem_done = 1'b1; load_use(3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    chk("pf_done_flush", 0, 1, 0, 0);
    nxt(); chk("pf_cleared", 0, 0, 0, 0);

    // reset mid-wait drops the pending flush
    nxt(); mem_stall = 1'b1; chk("rw_c1", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; branch_taken_ex = 1'b1; chk("rw_c2_branch", 0, 0, 1, 0);
    nxt(); mem_stall = 1'b1; rst = 1'b1; chk("rw_reset", 0, 0, 0, 0);
    nxt(); chk("rw_no_flush", 0, 0, 0, 0);
    nxt(); load_use(3'd1, 3'd0, 1'b0, 3'd1, 1'b1); chk("rw_lu_after", 1, 0, 0, 0);
    nxt(); chk("rw_sc1", 0, 0, 0, 0);

    // watchdog: RUN cycle + 255 MEMWAIT cycles frozen, then timeout
    for (int i = 0; i < 256; i++) begin
      nxt(); mem_stall = 1'b1; chk("wd_wait", 0, 0, 1, 0);
    end
    nxt(); mem_stall = 1'b1; chk("wd_expired", 0, 0, 0, 1);
    nxt(); mem_stall = 1'b1; branch_taken_ex = 1'b1; chk("wd_stall_ignored", 0, 1, 0, 1);
    nxt(); mem_stall = 1'b1; load_use(3'd2, 3'd2, 1'b1, 3'd0, 1'b0);
    chk("wd_lu_still_works", 1, 0, 0, 1);
    nxt(); chk("wd_sticky", 0, 0, 0, 1);
    nxt(); rst = 1'b1; chk("wd_reset", 0, 0, 0, 0);
    nxt(); mem_stall = 1'b1; chk("wd_rearmed", 0, 0, 1, 0);
    nxt(); mem_done = 1'b1; chk("wd_rearmed_done", 0, 0, 0, 0);
    nxt(); idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
